// File: rtl/hb_pkg.sv
// Shared types and constants for the heartbeat transmitter.
//   WIDTH      : phase/period width. It must match the downstream watchdog counter.
//   MAX_PERIOD : the largest period that still clears the watchdog before it saturates.
package hb_pkg;
  localparam int WIDTH = 4;
  typedef logic [WIDTH-1:0] size_t;
  localparam size_t MAX_PERIOD = size_t'(2**WIDTH - 2);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} hb_state_t;
  typedef logic [7:0] beat_cnt_t;

  function automatic logic period_legal(input size_t p);
    return (p != '0) && (p <= MAX_PERIOD);
  endfunction
endpackage

// File: rtl/hb_period_reg.sv
// Programmable period register with a sticky config-error flag.
//   i_clk, i_rst   : clock and async active-high reset
//   i_load         : single-cycle strobe that samples i_period
//   i_period       : requested period
//   period_q       : active period. It holds its value when a load is illegal.
//   cfg_err        : high from an illegal load until the next legal load
module hb_period_reg
  import hb_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] period_q,
  output logic             cfg_err
);

  logic [WIDTH-1:0] period_d;
  logic             cfg_err_d;
  logic             cfg_err_q;

  always_comb begin
    period_d  = period_q;
    cfg_err_d = cfg_err_q;
    if (i_load) begin
      if (period_legal(i_period)) begin
        period_d  = i_period;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      period_q  <= size_t'(DEFAULT_PERIOD);
      cfg_err_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/heartbeat_gen.sv
// Heartbeat transmitter. It sends periodic pulses that keep a downstream
// saturating watchdog counter from reaching all-ones.
//   i_clk, i_rst : clock and async active-high reset
//   i_enable     : run heartbeat generation
//   i_load       : strobe that samples i_period
//   i_period     : requested WAIT length
//   i_force      : request an immediate beat (honoured only in WAIT)
//   o_heartbeat  : registered pulse, high for PULSE_LEN cycles per beat
//   o_phase      : WAIT phase counter
//   o_busy       : high when the FSM is not in IDLE
//   o_cfg_err    : the last load was illegal
//   o_beats      : number of beats issued, saturating at 255
//
// state | meaning
// IDLE  | generation stopped, phase held at 0
// WAIT  | counting phase toward period_q-1
// BEAT  | o_heartbeat high for PULSE_LEN cycles
module heartbeat_gen
  import hb_pkg::*;
#(
  parameter int unsigned PULSE_LEN      = 1,
  parameter int unsigned DEFAULT_PERIOD = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_force,
  output logic             o_heartbeat,
  output logic [WIDTH-1:0] o_phase,
  output logic             o_busy,
  output logic             o_cfg_err,
  output logic [7:0]       o_beats
);

  localparam logic [1:0] PULSE_LAST = 2'(PULSE_LEN - 1);

  hb_state_t        state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [1:0]       pulse_q, pulse_d;
  beat_cnt_t        beats_q, beats_d;
  logic [WIDTH-1:0] period_q;
  logic             terminal;

  hb_period_reg #(
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_period (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (i_load),
    .i_period(i_period),
    .period_q(period_q),
    .cfg_err (o_cfg_err)
  );

  // The compare uses >= so that a shorter period loaded mid-WAIT fires on the
  // next cycle and does not let the phase run on toward all-ones.
  // period_q is never 0, so the subtraction cannot underflow.
  assign terminal = (phase_q >= (period_q - size_t'(1)));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    beats_d = beats_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (i_enable) state_d = WAIT;
      end
      WAIT: begin
        phase_d = phase_q + size_t'(1);
        if (!i_enable) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (terminal || i_force) begin
          state_d = BEAT;
          phase_d = '0;
          pulse_d = '0;
          if (beats_q != 8'hFF) beats_d = beats_q + 8'd1;
        end
      end
      BEAT: begin
        phase_d = '0;
        pulse_d = pulse_q + 2'd1;
        if (pulse_q == PULSE_LAST) begin
          pulse_d = '0;
          state_d = i_enable ? WAIT : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        pulse_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      beats_q <= beats_d;
    end
  end

  assign o_heartbeat = (state_q == BEAT);
  assign o_busy      = (state_q != IDLE);
  assign o_phase     = phase_q;
  assign o_beats     = beats_q;

endmodule
